// File: rtl/arb_mux_nx1_if.sv
// Handshake bundle for arb_mux_nx1: N producer channels merged onto one
// consumer, plus the mode/select controls that steer the merge.
interface arb_mux_nx1_if #(
  parameter int WIDTH = 64,
  parameter int N     = 8,
  parameter int SELW  = 3
);
  logic                  mode;
  logic [SELW-1:0]       select;
  logic [N*WIDTH-1:0]    in_data;
  logic [N-1:0]          in_valid;
  logic [N-1:0]          in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_chan;
  logic                  out_valid;
  logic                  out_ready;

  // Drives producers/consumer and controls (testbench or surrounding logic).
  modport master (
    output mode, select, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  // The selector itself.
  modport slave (
    input  mode, select, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/arb_mux_nx1.sv
// Registered N:1 selector with valid/ready handshaking. Mode 0 picks the
// channel named by select; mode 1 arbitrates round-robin starting after the
// last granted channel. A one-entry output register gives 1-cycle latency
// and full throughput (drain and load can happen in the same cycle).
module arb_mux_nx1 #(
  parameter int WIDTH = 64,
  parameter int N     = 8,
  parameter int SELW  = 3
) (
  input  logic          clk,
  input  logic          reset,
  arb_mux_nx1_if.slave  bus
);

  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  chan_q;
  logic             valid_q;
  logic [SELW-1:0]  ptr_q;

  logic             load_en;
  logic             grant;
  logic [SELW-1:0]  g;
  logic [SELW-1:0]  idx;
  logic [WIDTH-1:0] g_data;
  logic [N-1:0]     ready_c;

  // The register can take a new entry when empty or being drained this cycle.
  assign load_en = !valid_q || bus.out_ready;

  // Grant selection: direct index in mode 0, circular search from ptr+1 in mode 1.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    grant = 1'b0;
    g     = '0;
    idx   = '0;
    if (!bus.mode) begin
      // Out-of-range select matches no channel and therefore grants nothing.
      for (int i = 0; i < N; i++) begin
        if (bus.select == SELW'(i) && bus.in_valid[i]) begin
          grant = 1'b1;
          g     = SELW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = SELW'((int'(ptr_q) + k) % N);
        if (!grant && bus.in_valid[idx]) begin
          grant = 1'b1;
          g     = idx;
        end
      end
    end
  end

  // Data mux for the granted channel and the one-hot ready back to it.
  always_comb begin
    g_data  = '0;
    ready_c = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) begin
        g_data     = bus.in_data[i*WIDTH +: WIDTH];
        ready_c[i] = !reset && load_en && grant;
      end
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;

  // Output register and round-robin pointer update.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SELW'(N - 1);
    end else if (load_en && grant) begin
      data_q  <= g_data;
      chan_q  <= g;
      valid_q <= 1'b1;
      if (bus.mode) begin
        ptr_q <= g;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Self-checking bench for arb_mux_nx1. The main instance (64-bit, 8 channels)
// is tracked cycle by cycle by a behavioural model with a scoreboard queue; a
// second 6-channel instance covers out-of-range select.
module tb_arb_mux_nx1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arb_mux_nx1_if #(.WIDTH(64), .N(8), .SELW(3)) bus ();
  arb_mux_nx1 #(.WIDTH(64), .N(8), .SELW(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  arb_mux_nx1_if #(.WIDTH(16), .N(6), .SELW(3)) sbus ();
  arb_mux_nx1 #(.WIDTH(16), .N(6), .SELW(3)) dut_s (.clk(clk), .reset(reset), .bus(sbus));

  typedef struct {
    logic [63:0] data;
    int          chan;
  } entry_t;

  entry_t      sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        m_valid;
  int          m_ptr;
  logic [63:0] m_data;
  int          m_chan;
  bit          pend;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference arbitration for the 8-channel instance; -1 means no grant.
  function automatic int pick(logic md, int sel, logic [7:0] v, int p);
    if (!md) return v[sel] ? sel : -1;
    for (int k = 1; k <= 8; k++) begin
      int i = (p + k) % 8;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_data(input int seed);
    logic [15:0] s = seed[15:0];
    for (int i = 0; i < 8; i++) bus.in_data[i*64 +: 64] = {32'hDEAD_BEEF, s, 16'(i)};
  endtask

  // One clock: check outputs and ready at the falling edge, advance the model
  // at the rising edge, then return 1 time unit later for new stimulus.
  task automatic cycle();
    int          g;
    logic [7:0]  exp_rdy;
    logic        le;
    entry_t      e;
    @(negedge clk);
    if (pend) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e      = sb.pop_front();
        m_data = e.data;
        m_chan = e.chan;
      end
      pend = 1'b0;
    end
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_data", bus.out_data, m_data);
      check("out_chan", 64'(bus.out_chan), 64'(m_chan));
    end
    le      = !m_valid || bus.out_ready;
    g       = reset ? -1 : pick(bus.mode, int'(bus.select), bus.in_valid, m_ptr);
    exp_rdy = (le && g >= 0) ? (8'd1 << g) : 8'h00;
    check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0;
      m_ptr   = 7;
      pend    = 1'b0;
      sb.delete();
    end else if (le && g >= 0) begin
      sb.push_back('{bus.in_data[g*64 +: 64], g});
      pend    = 1'b1;
      m_valid = 1'b1;
      if (bus.mode) m_ptr = g;
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int rr_exp[8] = '{0, 2, 5, 7, 0, 2, 5, 7};

    reset         = 1'b1;
    bus.mode      = 1'b1;
    bus.select    = '0;
    bus.in_valid  = 8'hFF;
    bus.out_ready = 1'b1;
    set_data(0);
    sbus.mode      = 1'b0;
    sbus.select    = '0;
    sbus.in_valid  = '0;
    sbus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) sbus.in_data[i*16 +: 16] = 16'hA000 + 16'(i);
    m_valid = 1'b0;
    m_ptr   = 7;
    pend    = 1'b0;
    m_data  = '0;
    m_chan  = 0;

    // Reset held with every channel valid: nothing may be granted.
    @(posedge clk); #1;
    cycle();
    cycle();
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_out_chan", 64'(bus.out_chan), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);

    // First round-robin grant after reset goes to channel 0.
    reset = 1'b0;
    cycle();
    check("rr_first_chan", 64'(bus.out_chan), 64'd0);

    // Direct select of channel 5.
    bus.mode   = 1'b0;
    bus.select = 3'd5;
    cycle();
    check("direct_data", bus.out_data, 64'hDEAD_BEEF_0000_0005);
    check("direct_chan", 64'(bus.out_chan), 64'd5);

    // Round-robin sequence over a sparse valid mask, from a fresh pointer.
    reset = 1'b1;
    cycle();
    reset        = 1'b0;
    bus.mode     = 1'b1;
    bus.in_valid = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      set_data(100 + i);
      cycle();
      check("rr_seq", 64'(bus.out_chan), 64'(rr_exp[i]));
    end

    // Backpressure: the held entry (channel 7) must stay put for 4 cycles.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_data(200 + i);
      cycle();
      check("bp_hold_chan", 64'(bus.out_chan), 64'd7);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_resume_chan", 64'(bus.out_chan), 64'd0);
    check("bp_no_bubble", 64'(bus.out_valid), 64'd1);

    // Mid-stream reset discards the entry and rewinds the pointer.
    cycle();
    reset = 1'b1;
    cycle();
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    reset        = 1'b0;
    bus.in_valid = 8'b1010_0100;
    cycle();
    check("mid_rst_grant", 64'(bus.out_chan), 64'd2);

    // Random mix of modes, selects, valids and stalls against the model.
    for (int i = 0; i < 60; i++) begin
      bus.mode      = 1'($urandom_range(0, 1));
      bus.select    = 3'($urandom_range(0, 7));
      bus.in_valid  = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      set_data(300 + i);
      cycle();
    end
    bus.in_valid  = 8'h00;
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // Six-channel instance: in-range select, then out-of-range and invalid.
    sbus.mode     = 1'b0;
    sbus.select   = 3'd2;
    sbus.in_valid = 6'h3F;
    @(negedge clk);
    check("s_ready_sel2", 64'(sbus.in_ready), 64'h04);
    @(posedge clk); #1;
    check("s_valid_sel2", 64'(sbus.out_valid), 64'd1);
    check("s_chan_sel2", 64'(sbus.out_chan), 64'd2);
    check("s_data_sel2", 64'(sbus.out_data), 64'hA002);
    sbus.select = 3'd7;
    @(negedge clk);
    check("s_ready_oor", 64'(sbus.in_ready), 64'h00);
    @(posedge clk); #1;
    check("s_drain_oor", 64'(sbus.out_valid), 64'd0);
    sbus.select   = 3'd3;
    sbus.in_valid = 6'b11_0111;
    @(negedge clk);
    check("s_ready_inval", 64'(sbus.in_ready), 64'h00);
    @(posedge clk); #1;
    check("s_valid_inval", 64'(sbus.out_valid), 64'd0);
    // Mode-0 traffic left the pointer at N-1, so channel 0 wins first.
    sbus.mode     = 1'b1;
    sbus.in_valid = 6'h3F;
    @(negedge clk);
    check("s_ready_rr", 64'(sbus.in_ready), 64'h01);
    @(posedge clk); #1;
    check("s_chan_rr", 64'(sbus.out_chan), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
